// File: rtl/buf_id_pool_if.sv
// Handshake/bus bundle between data_ctrl, the scheduler and buf_id_pool.
// The slave modport is the pool side. The master modport is the requester side.
// Address width is derived from the ID width and the slot shift.
interface buf_id_pool_if #(
   parameter int ID_WIDTH   = 4,
   parameter int SLOT_SHIFT = 7
);
   localparam int ADDR_WIDTH = ID_WIDTH + SLOT_SHIFT;

   logic                  init_done;
   logic                  alloc_req;
   logic                  alloc_grant;
   logic [ID_WIDTH-1:0]   alloc_id;
   logic [ADDR_WIDTH-1:0] alloc_waddr;
   logic                  rd_req;
   logic [ID_WIDTH-1:0]   rd_id;
   logic [ADDR_WIDTH-1:0] rd_raddr;
   logic                  rd_raddr_wr;
   logic                  rel_wr;
   logic [ID_WIDTH-1:0]   rel_id;
   logic [ID_WIDTH:0]     free_count;
   logic                  pool_empty;
   logic                  err_dfree;

   modport slave (
      input  alloc_req, rd_req, rd_id, rel_wr, rel_id,
      output init_done, alloc_grant, alloc_id, alloc_waddr, rd_raddr, rd_raddr_wr,
             free_count, pool_empty, err_dfree
   );

   modport master (
      output alloc_req, rd_req, rd_id, rel_wr, rel_id,
      input  init_done, alloc_grant, alloc_id, alloc_waddr, rd_raddr, rd_raddr_wr,
             free_count, pool_empty, err_dfree
   );
endinterface

// File: rtl/buf_id_pool.sv
// Free-buffer-ID pool: a circular free list hands out IDs and base addresses, maps read IDs to addresses, and takes IDs back.
// Latency: a grant, a read address or an error pulse appears one cycle after the request. After reset, INIT takes 2**ID_WIDTH cycles.
// Backpressure: alloc_req is a level signal that is granted every cycle while the pool is non-empty. Releases into a full pool are rejected with err_dfree.
// Optional ID_POOL_DFREE_CHK_EN: an allocated-ID bitmap also rejects double or unknown frees.
module buf_id_pool #(
   parameter int ID_WIDTH   = 4,
   parameter int SLOT_SHIFT = 7
) (
   input  logic           clk,
   input  logic           rst_n,
   buf_id_pool_if.slave   bus
);
   localparam int ADDR_WIDTH = ID_WIDTH + SLOT_SHIFT;
   localparam int N          = 1 << ID_WIDTH;
   localparam logic [ID_WIDTH:0] FULL_CNT = (ID_WIDTH+1)'(N);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_run;
   logic                  w_init_wr;

   logic [ID_WIDTH-1:0]   r_list [N];
   logic [ID_WIDTH-1:0]   r_rd_ptr;
   logic [ID_WIDTH-1:0]   r_wr_ptr;
   logic [ID_WIDTH:0]     r_free_count;

   logic                  r_alloc_grant;
   logic [ID_WIDTH-1:0]   r_alloc_id;
   logic                  r_rd_raddr_wr;
   logic [ID_WIDTH-1:0]   r_rd_id;
   logic                  r_err_dfree;

   logic                  w_grant;
   logic                  w_rel_known;
   logic                  w_rel_ok;
   logic                  w_rel_err;
   logic                  w_push;
   logic [ID_WIDTH-1:0]   w_push_id;
   logic [ADDR_WIDTH-1:0] w_alloc_waddr;
   logic [ADDR_WIDTH-1:0] w_rd_raddr;

   // FSM state register: reset always restarts the INIT fill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_INIT;
      else        r_state <= w_state_nxt;
   end

   // Next state: leave INIT on the cycle that writes the last ID. RUN is left only by reset.
   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_INIT && r_free_count == FULL_CNT - 1'b1)
         w_state_nxt = ST_RUN;
   end

   // FSM outputs: INIT writes one ID per cycle, RUN serves requests.
   always_comb begin
      w_run     = 1'b0;
      w_init_wr = 1'b0;
      case (r_state)
         ST_INIT: w_init_wr = 1'b1;
         ST_RUN:  w_run     = 1'b1;
         default: ;
      endcase
   end

`ifdef ID_POOL_DFREE_CHK_EN
   logic [N-1:0] r_alloc_map;

   // Allocated bitmap: set on grant, cleared on accepted release. The release sees the pre-grant map.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alloc_map <= '0;
      end else begin
         if (w_rel_ok) r_alloc_map[bus.rel_id] <= 1'b0;
         if (w_grant)  r_alloc_map[r_list[r_rd_ptr]] <= 1'b1;
      end
   end

   assign w_rel_known = r_alloc_map[bus.rel_id];
`else
   assign w_rel_known = 1'b1;
`endif

   // The grant decision uses the current count, so a release into an empty pool grants on the next cycle.
   assign w_grant   = w_run & bus.alloc_req & (r_free_count != '0);
   assign w_rel_ok  = w_run & bus.rel_wr & (r_free_count != FULL_CNT) & w_rel_known;
   assign w_rel_err = w_run & bus.rel_wr & ~w_rel_ok;
   assign w_push    = w_init_wr | w_rel_ok;
   assign w_push_id = w_init_wr ? r_wr_ptr : bus.rel_id;

   // Free list storage: INIT writes the ID equal to the pointer, RUN pushes released IDs at the tail.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) r_list[i] <= '0;
      end else if (w_push) begin
         r_list[r_wr_ptr] <= w_push_id;
      end
   end

   // Pointers wrap modulo N. The count moves by push minus pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr     <= '0;
         r_wr_ptr     <= '0;
         r_free_count <= '0;
      end else begin
         if (w_push)  r_wr_ptr <= r_wr_ptr + ID_WIDTH'(1);
         if (w_grant) r_rd_ptr <= r_rd_ptr + ID_WIDTH'(1);
         r_free_count <= r_free_count + (ID_WIDTH+1)'(w_push) - (ID_WIDTH+1)'(w_grant);
      end
   end

   // Registered responses: one-cycle pulses. The ID and read ID hold between pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alloc_grant <= 1'b0;
         r_alloc_id    <= '0;
         r_rd_raddr_wr <= 1'b0;
         r_rd_id       <= '0;
         r_err_dfree   <= 1'b0;
      end else begin
         r_alloc_grant <= w_grant;
         if (w_grant) r_alloc_id <= r_list[r_rd_ptr];
         r_rd_raddr_wr <= w_run & bus.rd_req;
         if (w_run & bus.rd_req) r_rd_id <= bus.rd_id;
         r_err_dfree   <= w_rel_err;
      end
   end

   assign w_alloc_waddr   = {r_alloc_id, {SLOT_SHIFT{1'b0}}};
   assign w_rd_raddr      = {r_rd_id, {SLOT_SHIFT{1'b0}}};

   assign bus.init_done   = w_run;
   assign bus.alloc_grant = r_alloc_grant;
   assign bus.alloc_id    = r_alloc_id;
   assign bus.alloc_waddr = w_alloc_waddr;
   assign bus.rd_raddr    = w_rd_raddr;
   assign bus.rd_raddr_wr = r_rd_raddr_wr;
   assign bus.free_count  = r_free_count;
   assign bus.pool_empty  = (r_free_count == '0);
   assign bus.err_dfree   = r_err_dfree;
endmodule

// File: tb/tb_buf_id_pool.sv
// Directed bench for buf_id_pool with ID_WIDTH=4 and SLOT_SHIFT=7.
// Inputs are driven 1 ns after the rising edge, and outputs are sampled at the same point.
// Expected values are hand-computed. Define ID_POOL_DFREE_CHK_EN for both the bench and the RTL.
module tb_buf_id_pool;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk  = 0;
   int   n_pass = 0;

   buf_id_pool_if #(.ID_WIDTH(4), .SLOT_SHIFT(7)) bus ();

   buf_id_pool #(.ID_WIDTH(4), .SLOT_SHIFT(7)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_init();
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i == 15) begin
            chk("init_done_pre", 32'(bus.init_done), 32'd0);
            chk("init_cnt15", 32'(bus.free_count), 32'd15);
         end
      end
      chk("init_done", 32'(bus.init_done), 32'd1);
      chk("init_cnt16", 32'(bus.free_count), 32'd16);
   endtask

   initial begin
      bus.alloc_req = 1'b0;
      bus.rd_req    = 1'b0;
      bus.rd_id     = '0;
      bus.rel_wr    = 1'b0;
      bus.rel_id    = '0;
      tick();
      tick();
      chk("rst_init_done", 32'(bus.init_done), 32'd0);
      chk("rst_count", 32'(bus.free_count), 32'd0);
      chk("rst_empty", 32'(bus.pool_empty), 32'd1);
      chk("rst_grant", 32'(bus.alloc_grant), 32'd0);
      chk("rst_id", 32'(bus.alloc_id), 32'd0);
      chk("rst_waddr", 32'(bus.alloc_waddr), 32'd0);
      chk("rst_raddr", 32'(bus.rd_raddr), 32'd0);
      chk("rst_err", 32'(bus.err_dfree), 32'd0);

      // Requests made during INIT must be ignored.
      rst_n = 1'b1;
      bus.alloc_req = 1'b1;
      bus.rd_req    = 1'b1;
      bus.rd_id     = 4'h3;
      bus.rel_wr    = 1'b1;
      bus.rel_id    = 4'h3;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("init_no_grant", 32'(bus.alloc_grant), 32'd0);
         chk("init_no_rdwr", 32'(bus.rd_raddr_wr), 32'd0);
         chk("init_no_err", 32'(bus.err_dfree), 32'd0);
      end
      bus.alloc_req = 1'b0;
      bus.rd_req    = 1'b0;
      bus.rel_wr    = 1'b0;
      for (int i = 4; i <= 16; i++) begin
         tick();
         if (i == 15) chk("init_done_pre", 32'(bus.init_done), 32'd0);
      end
      chk("init_done", 32'(bus.init_done), 32'd1);
      chk("init_cnt16", 32'(bus.free_count), 32'd16);
      chk("init_not_empty", 32'(bus.pool_empty), 32'd0);

      // Three grants: IDs 0, 1, 2.
      bus.alloc_req = 1'b1;
      tick();
      chk("g0_vld", 32'(bus.alloc_grant), 32'd1);
      chk("g0_id", 32'(bus.alloc_id), 32'd0);
      chk("g0_waddr", 32'(bus.alloc_waddr), 32'h000);
      tick();
      chk("g1_id", 32'(bus.alloc_id), 32'd1);
      chk("g1_waddr", 32'(bus.alloc_waddr), 32'h080);
      tick();
      bus.alloc_req = 1'b0;
      chk("g2_vld", 32'(bus.alloc_grant), 32'd1);
      chk("g2_id", 32'(bus.alloc_id), 32'd2);
      chk("g2_waddr", 32'(bus.alloc_waddr), 32'h100);
      chk("g2_count", 32'(bus.free_count), 32'd13);
      tick();
      chk("g_idle", 32'(bus.alloc_grant), 32'd0);
      chk("g_hold_id", 32'(bus.alloc_id), 32'd2);

      // Read-address translation.
      bus.rd_req = 1'b1;
      bus.rd_id  = 4'hA;
      tick();
      bus.rd_req = 1'b0;
      chk("rd_raddr", 32'(bus.rd_raddr), 32'h500);
      chk("rd_wr", 32'(bus.rd_raddr_wr), 32'd1);
      chk("rd_count", 32'(bus.free_count), 32'd13);
      tick();
      chk("rd_wr_pulse", 32'(bus.rd_raddr_wr), 32'd0);
      chk("rd_hold", 32'(bus.rd_raddr), 32'h500);

      // Drain the pool: 13 more grants (IDs 3..15), then none.
      bus.alloc_req = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (i < 13) begin
            chk("drain_vld", 32'(bus.alloc_grant), 32'd1);
            chk("drain_id", 32'(bus.alloc_id), 32'(3 + i));
         end else begin
            chk("drain_none", 32'(bus.alloc_grant), 32'd0);
         end
      end
      bus.alloc_req = 1'b0;
      chk("drain_empty", 32'(bus.pool_empty), 32'd1);
      chk("drain_count", 32'(bus.free_count), 32'd0);

      // Release ID 5 and grant it again.
      bus.rel_wr = 1'b1;
      bus.rel_id = 4'd5;
      tick();
      bus.rel_wr = 1'b0;
      chk("rel5_count", 32'(bus.free_count), 32'd1);
      chk("rel5_err", 32'(bus.err_dfree), 32'd0);
      bus.alloc_req = 1'b1;
      tick();
      bus.alloc_req = 1'b0;
      chk("regrant5_vld", 32'(bus.alloc_grant), 32'd1);
      chk("regrant5_id", 32'(bus.alloc_id), 32'd5);
      chk("regrant5_cnt", 32'(bus.free_count), 32'd0);

      // Empty pool: allocation and release in the same cycle.
      bus.alloc_req = 1'b1;
      bus.rel_wr    = 1'b1;
      bus.rel_id    = 4'd9;
      tick();
      bus.rel_wr = 1'b0;
      chk("sim_no_grant", 32'(bus.alloc_grant), 32'd0);
      chk("sim_count1", 32'(bus.free_count), 32'd1);
      tick();
      bus.alloc_req = 1'b0;
      chk("sim_grant", 32'(bus.alloc_grant), 32'd1);
      chk("sim_id9", 32'(bus.alloc_id), 32'd9);
      chk("sim_count0", 32'(bus.free_count), 32'd0);

      // Return every ID, so the pool is full again (0..15 pushed in order).
      for (int i = 0; i < 16; i++) begin
         bus.rel_wr = 1'b1;
         bus.rel_id = 4'(i);
         tick();
         chk("refill_err", 32'(bus.err_dfree), 32'd0);
      end
      bus.rel_wr = 1'b0;
      chk("refill_count", 32'(bus.free_count), 32'd16);

      // Release into a full pool is rejected.
      bus.rel_wr = 1'b1;
      bus.rel_id = 4'd3;
      tick();
      bus.rel_wr = 1'b0;
      chk("full_err", 32'(bus.err_dfree), 32'd1);
      chk("full_count", 32'(bus.free_count), 32'd16);
      tick();
      chk("full_err_pulse", 32'(bus.err_dfree), 32'd0);

      // Allocation and release in the same cycle at N: grant issued, release rejected.
      bus.alloc_req = 1'b1;
      bus.rel_wr    = 1'b1;
      bus.rel_id    = 4'd3;
      tick();
      bus.alloc_req = 1'b0;
      bus.rel_wr    = 1'b0;
      chk("fullsim_grant", 32'(bus.alloc_grant), 32'd1);
      chk("fullsim_id", 32'(bus.alloc_id), 32'd0);
      chk("fullsim_err", 32'(bus.err_dfree), 32'd1);
      chk("fullsim_count", 32'(bus.free_count), 32'd15);

      // Release of ID 7, which was never granted from this fill.
      bus.rel_wr = 1'b1;
      bus.rel_id = 4'd7;
      tick();
      bus.rel_wr = 1'b0;
`ifdef ID_POOL_DFREE_CHK_EN
      chk("dfree_err", 32'(bus.err_dfree), 32'd1);
      chk("dfree_count", 32'(bus.free_count), 32'd15);
`else
      chk("nochk_err", 32'(bus.err_dfree), 32'd0);
      chk("nochk_count", 32'(bus.free_count), 32'd16);
`endif

      // Reset in the middle of a grant stream.
      bus.alloc_req = 1'b1;
      tick();
      chk("pre_rst_grant", 32'(bus.alloc_grant), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_grant", 32'(bus.alloc_grant), 32'd0);
      chk("arst_id", 32'(bus.alloc_id), 32'd0);
      chk("arst_waddr", 32'(bus.alloc_waddr), 32'd0);
      chk("arst_count", 32'(bus.free_count), 32'd0);
      chk("arst_init_done", 32'(bus.init_done), 32'd0);
      chk("arst_empty", 32'(bus.pool_empty), 32'd1);
      chk("arst_raddr", 32'(bus.rd_raddr), 32'd0);
      bus.alloc_req = 1'b0;
      tick();
      rst_n = 1'b1;
      run_init();
      bus.alloc_req = 1'b1;
      tick();
      chk("restart_id0", 32'(bus.alloc_id), 32'd0);
      chk("restart_vld", 32'(bus.alloc_grant), 32'd1);
      tick();
      bus.alloc_req = 1'b0;
      chk("restart_id1", 32'(bus.alloc_id), 32'd1);
      chk("restart_waddr", 32'(bus.alloc_waddr), 32'h080);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
